// File: rtl/mmio_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mmio_uart_tx : MMIO-mapped 8N1 UART transmitter with TX FIFO               |
// | Optional IRQ output/CTRL register: define MMIO_UART_TX_IRQ_EN  | rev 1.0   |
// +----------------------------------------------------------------------------+
module mmio_uart_tx #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [29:0] i_addr,
  input  logic [31:0] i_data,
  input  logic        i_wren,
  input  logic [3:0]  i_mask,
  output logic [31:0] o_data,
`ifdef MMIO_UART_TX_IRQ_EN
  output logic        o_irq,
`endif
  output logic        o_tx
);

  localparam int unsigned c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned c_LVL_W = c_PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic                 tx_q, tx_d;
  logic [7:0]           shift_q, shift_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [15:0]          baud_cnt_q, baud_cnt_d;
  logic [15:0]          div_act_q, div_act_d;
  logic [15:0]          baud_div_q;
  logic                 ovf_q;
  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [c_PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [c_LVL_W-1:0]   level_q, level_d;

  logic                 w_write;
  logic                 w_sel_tx, w_sel_stat, w_sel_baud, w_sel_ctrl;
  logic                 w_push_req, w_push, w_pop;
  logic                 w_full, w_empty, w_busy;
  logic                 w_bit_end, w_load;
  logic [15:0]          w_div_eff;
  logic [7:0]           w_level8;
  logic                 w_ctrl_rd;
  logic                 w_unused;

  assign w_write    = i_wren & (|i_mask);
  assign w_sel_tx   = (i_addr[1:0] == 2'd0);
  assign w_sel_stat = (i_addr[1:0] == 2'd1);
  assign w_sel_baud = (i_addr[1:0] == 2'd2);
  assign w_sel_ctrl = (i_addr[1:0] == 2'd3);

  assign w_full     = (level_q == c_LVL_W'(FIFO_DEPTH));
  assign w_empty    = (level_q == '0);
  assign w_busy     = (state_q != S_IDLE);
  // Full is judged on the pre-pop level, so a push is dropped even when a pop coincides.
  assign w_push_req = w_write & w_sel_tx & i_mask[0];
  assign w_push     = w_push_req & ~w_full;
  assign w_pop      = w_load;

  assign w_div_eff  = (baud_div_q == 16'd0) ? 16'd1 : baud_div_q;
  assign w_bit_end  = (baud_cnt_q == (div_act_q - 16'd1));
  assign w_load     = ~w_empty & ((state_q == S_IDLE) | ((state_q == S_STOP) & w_bit_end));

  assign w_level8   = 8'(level_q);
  assign w_unused   = &{1'b0, i_addr[29:2], i_data[31:16]};

  // FIFO storage carries no reset; flushing is done through the pointers.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= i_data[7:0];
    end
  end

  always_comb begin
    level_d = level_q;
    case ({w_push, w_pop})
      2'b10:   level_d = level_q + c_LVL_W'(1);
      2'b01:   level_d = level_q - c_LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + c_PTR_W'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      baud_div_q <= DEFAULT_DIV;
      ovf_q      <= 1'b0;
    end else begin
      if (w_write & w_sel_baud) begin
        if (i_mask[0]) baud_div_q[7:0]  <= i_data[7:0];
        if (i_mask[1]) baud_div_q[15:8] <= i_data[15:8];
      end
      if (w_push_req & w_full) begin
        ovf_q <= 1'b1;
      end else if (w_write & w_sel_stat & i_mask[0] & i_data[3]) begin
        ovf_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    div_act_d  = div_act_q;
    baud_cnt_d = w_bit_end ? 16'd0 : (baud_cnt_q + 16'd1);
    case (state_q)
      S_IDLE: begin
        tx_d       = 1'b1;
        baud_cnt_d = 16'd0;
      end
      S_START: begin
        if (w_bit_end) begin
          state_d   = S_DATA;
          tx_d      = shift_q[0];
          bit_cnt_d = 3'd0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (bit_cnt_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    // Frame start, from IDLE or straight out of STOP for back-to-back bytes.
    if (w_load) begin
      state_d    = S_START;
      tx_d       = 1'b0;
      shift_d    = mem_q[rd_ptr_q];
      div_act_d  = w_div_eff;
      baud_cnt_d = 16'd0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      tx_q       <= 1'b1;
      shift_q    <= 8'd0;
      bit_cnt_q  <= 3'd0;
      baud_cnt_q <= 16'd0;
      div_act_q  <= 16'd1;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_cnt_q <= baud_cnt_d;
      div_act_q  <= div_act_d;
    end
  end

  assign o_tx = tx_q;

`ifdef MMIO_UART_TX_IRQ_EN
  logic irq_en_q;
  logic irq_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (w_write & w_sel_ctrl & i_mask[0]) irq_en_q <= i_data[0];
      irq_q <= irq_en_q & w_empty & ~w_busy;
    end
  end

  assign o_irq     = irq_q;
  assign w_ctrl_rd = irq_en_q;
`else
  assign w_ctrl_rd = 1'b0 & w_sel_ctrl;
`endif

  always_comb begin
    o_data = 32'd0;
    case (i_addr[1:0])
      2'd1:    o_data = {16'd0, w_level8, 4'd0, ovf_q, w_busy, w_empty, w_full};
      2'd2:    o_data = {16'd0, baud_div_q};
      2'd3:    o_data = {31'd0, w_ctrl_rd};
      default: o_data = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mmio_uart_tx : randomized bench vs. frame-level reference model | rev 1.0|
// +----------------------------------------------------------------------------+
module tb_mmio_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic        wren;
  logic [3:0]  mask;
  logic [31:0] rdata;
  logic        tx;
`ifdef MMIO_UART_TX_IRQ_EN
  logic        irq;
`endif

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (16'd434)
  ) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_addr  (addr),
    .i_data  (wdata),
    .i_wren  (wren),
    .i_mask  (mask),
    .o_data  (rdata),
`ifdef MMIO_UART_TX_IRQ_EN
    .o_irq   (irq),
`endif
    .o_tx    (tx)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: a frame is (start edge, divider, byte); the line level is
  // derived from the bit index (cycles since start) / divider.
  logic [7:0]  mq[$];
  int          cyc;
  bit          m_active;
  int          m_start;
  int          m_div;
  logic [7:0]  m_byte;
  logic [15:0] m_baud;
  bit          m_ovf;
  bit          m_irq_en;
  bit          m_irq;

  function automatic void model_reset();
    mq.delete();
    m_active = 1'b0;
    m_baud   = 16'd434;
    m_ovf    = 1'b0;
    m_irq_en = 1'b0;
    m_irq    = 1'b0;
  endfunction

  function automatic void model_edge();
    bit full_pre;
    bit wr;
    full_pre = (mq.size() == 8);
    wr       = wren && (mask != 4'd0);
    m_irq    = m_irq_en && (mq.size() == 0) && !m_active;
    if (!m_active || (cyc == m_start + 10 * m_div)) begin
      if (mq.size() > 0) begin
        m_byte   = mq.pop_front();
        m_start  = cyc;
        m_div    = (m_baud == 16'd0) ? 1 : int'(m_baud);
        m_active = 1'b1;
      end else begin
        m_active = 1'b0;
      end
    end
    if (wr) begin
      case (addr[1:0])
        2'd0: if (mask[0]) begin
          if (full_pre) m_ovf = 1'b1;
          else          mq.push_back(wdata[7:0]);
        end
        2'd1: if (mask[0] && wdata[3]) m_ovf = 1'b0;
        2'd2: begin
          if (mask[0]) m_baud[7:0]  = wdata[7:0];
          if (mask[1]) m_baud[15:8] = wdata[15:8];
        end
        default: begin
`ifdef MMIO_UART_TX_IRQ_EN
          if (mask[0]) m_irq_en = wdata[0];
`endif
        end
      endcase
    end
  endfunction

  function automatic logic exp_tx();
    int k;
    if (!m_active) return 1'b1;
    k = (cyc - m_start) / m_div;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    logic [7:0] lvl;
    lvl = 8'(mq.size());
    case (a)
      2'd1: return {16'd0, lvl, 4'd0, m_ovf, m_active, (mq.size() == 0), (mq.size() == 8)};
      2'd2: return {16'd0, m_baud};
`ifdef MMIO_UART_TX_IRQ_EN
      2'd3: return {31'd0, m_irq_en};
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check_eq("tx", {31'd0, tx}, {31'd0, exp_tx()});
    check_eq($sformatf("rd%0d", addr[1:0]), rdata, exp_rd(addr[1:0]));
`ifdef MMIO_UART_TX_IRQ_EN
    check_eq("irq", {31'd0, irq}, {31'd0, m_irq});
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] m);
    addr  = {28'($urandom), a};
    wdata = d;
    mask  = m;
    wren  = 1'b1;
    step();
    wren  = 1'b0;
    mask  = 4'd0;
    addr  = 30'd1;
  endtask

  task automatic hold_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    addr  = 30'd1;
    wdata = 32'd0;
    wren  = 1'b0;
    mask  = 4'd0;
    cyc   = 0;
    hold_reset();

    // Reset state.
    check_eq("rst_tx", {31'd0, tx}, 32'd1);
    check_eq("rst_status", rdata, 32'h0000_0002);
    addr = 30'd2;
    #1;
    check_eq("rst_baud", rdata, 32'd434);
    addr = 30'd1;
    idle(2);

    // DIV=4, single byte 0x55.
    wr(2'd2, 32'd4, 4'b0011);
    wr(2'd0, 32'h55, 4'b0001);
    idle(45);

    // DIV=2, back-to-back bytes.
    wr(2'd2, 32'd2, 4'b0011);
    wr(2'd0, 32'hA5, 4'b0001);
    wr(2'd0, 32'h3C, 4'b0001);
    idle(50);

    // Overflow: one byte in flight, eight queued, a ninth dropped.
    wr(2'd2, 32'd3, 4'b0011);
    for (int i = 0; i < 10; i++) wr(2'd0, 32'(8'h10 + i), 4'b0001);
    wr(2'd0, 32'h77, 4'b0000);
    wr(2'd1, 32'h8, 4'b0001);
    idle(300);

    // DIV=0 behaves as 1; a mid-frame divider write only hits the next frame.
    wr(2'd2, 32'd0, 4'b0011);
    wr(2'd0, 32'hFF, 4'b0001);
    wr(2'd2, 32'd8, 4'b0001);
    wr(2'd0, 32'h81, 4'b0001);
    idle(100);

`ifdef MMIO_UART_TX_IRQ_EN
    wr(2'd3, 32'd1, 4'b0001);
    wr(2'd2, 32'd2, 4'b0011);
    wr(2'd0, 32'hC3, 4'b0001);
    idle(25);
    wr(2'd3, 32'd0, 4'b0001);
`endif

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 55) begin
        addr  = {28'($urandom), 2'($urandom)};
        wren  = 1'($urandom);
        mask  = 4'd0;
        wdata = $urandom;
        step();
        wren  = 1'b0;
      end else if (r < 80) begin
        wr(2'd0, $urandom, 4'($urandom));
      end else if (r < 88) begin
        wr(2'd2, 32'($urandom_range(0, 5)), 4'($urandom));
      end else if (r < 95) begin
        wr(2'd1, $urandom, 4'($urandom));
      end else begin
        wr(2'd3, $urandom, 4'($urandom));
      end
    end
    wr(2'd2, 32'd2, 4'b0011);
    idle(600);

    // Asynchronous reset during data bit 3.
    wr(2'd2, 32'd4, 4'b0011);
    wr(2'd0, 32'h5A, 4'b0001);
    idle(18);
    check_eq("pre_rst_tx", {31'd0, tx}, {31'd0, exp_tx()});
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_tx", {31'd0, tx}, 32'd1);
    hold_reset();
    addr = 30'd1;
    #1;
    check_eq("post_rst_status", rdata, 32'h0000_0002);
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the MMIO side of the data-memory crossbar.
- Consumes the crossbar's MMIO request: word address already rebased to the MMIO window, write data, select/write strobe and byte mask.
- Returns read data combinationally in the same cycle.
- Buffers bytes in a small FIFO and serialises them 8N1 on o_tx.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; power of two, ≥2.
- DEFAULT_DIV, 16'd434, reset value of BAUD_DIV (clock cycles per bit).

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_addr  in  30  word offset within MMIO window; only i_addr[1:0] decoded, upper bits alias.
- i_data  in  32  write data.
- i_wren  in  1  block selected by crossbar.
- i_mask  in  4  byte-enable mask.
- o_data  out  32  read data, combinational from i_addr and state.
- o_tx  out  1  serial line, idle high.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous, active-low.
- Write condition: a write occurs on a rising edge when i_wren=1 and i_mask≠0. i_wren with i_mask=0 is a read only and has no side effects.
- Register map (word offset):
  - 0 TXDATA: write with i_mask[0]=1 pushes i_data[7:0]. Reads return 0.
  - 1 STATUS (read): bit0 full, bit1 empty, bit2 busy (FSM≠IDLE), bit3 overflow (sticky), bits[15:8] FIFO level. Writing 1 to bit3 with i_mask[0]=1 clears overflow. Other bits are read-only.
  - 2 BAUD_DIV: bits[15:0], read/write per byte mask. Bits[31:16] read 0.
  - 3 CTRL: see Optional Feature. Reads 0 when the feature is compiled out.
- Reset values: o_tx=1, FIFO empty, overflow=0, BAUD_DIV=DEFAULT_DIV, FSM=IDLE, bit counter=0, baud counter=0.
- FIFO:
  - Push on a TXDATA write when not full.
  - A push while full is dropped and sets overflow. This holds even if a pop happens in the same cycle; full is evaluated before the pop.
  - A simultaneous push and pop when not full leaves the level unchanged.
- FSM IDLE→START→DATA→STOP:
  - IDLE: if FIFO non-empty at an edge, pop head into the shift register, latch BAUD_DIV into the active divider (a value of 0 is treated as 1), go to START, and drive o_tx=0 from that edge.
  - Latency: a byte written at edge E appears as o_tx falling at edge E+1 when idle.
  - Each bit lasts exactly DIV cycles.
  - START lasts 1 bit, then DATA.
  - DATA: 8 bits, LSB first.
  - STOP: o_tx=1 for 1 bit. At the end of STOP, if the FIFO is non-empty, pop and go directly to START with no idle cycle; else go to IDLE.
  - Frame length is exactly 10·DIV cycles.
- BAUD_DIV writes mid-frame do not affect the current frame; they take effect at the next frame start.
- Reset mid-frame: o_tx returns to 1 immediately (asynchronously), the FIFO is flushed, and the FSM goes to IDLE.
- FIFO pointers wrap modulo FIFO_DEPTH. Level range is 0..FIFO_DEPTH.

Optional Feature:
- Macro: MMIO_UART_TX_IRQ_EN.
- When defined:
  - Adds output o_irq (1 bit, registered, reset 0).
  - CTRL bit0 = irq_en (reset 0, writable with i_mask[0]).
  - o_irq = irq_en & FIFO empty & FSM IDLE, registered one cycle after the condition holds.
  - CTRL reads back irq_en.
- When undefined: no o_irq port, CTRL writes are ignored, CTRL reads 0.

Test Plan:
- Reset, then read STATUS → 0x0000_0002 (empty); o_tx=1; BAUD_DIV reads 434.
- Write BAUD_DIV=4, write TXDATA=0x55 at edge E → o_tx=0 over cycles E+1..E+4, then data bits 1,0,1,0,1,0,1,0 (4 cycles each), then stop high. Frame totals 40 cycles; busy=1 throughout.
- With DIV=2, write 0xA5 then 0x3C back-to-back → two frames with no idle cycle between the first stop bit and the second start bit; STATUS level reads 1 after the first pop.
- Fill 8 bytes while the FSM is transmitting, then write a 9th → 9th dropped, STATUS bit3=1, level=8. Write STATUS 0x8 → overflow cleared.
- Write BAUD_DIV=0, send 0xFF → each bit 1 cycle, frame 10 cycles. Write BAUD_DIV=8 mid-frame → current frame unaffected, next frame uses 8.
- Assert i_rst_n=0 during DATA bit 3 → o_tx=1 immediately, STATUS=0x2 after release. With MMIO_UART_TX_IRQ_EN defined: set CTRL=1, send 1 byte → o_irq=0 during the frame, o_irq=1 one cycle after return to IDLE.
